// File: rtl/multicast_issue_buffer.sv
// Packet FIFO feeding a combinational multicast chain. Each destination is retired
// as its node becomes ready, and the head is popped once its last destination is served.
module multicast_issue_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_NODE   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  input  logic [DATA_WIDTH-1:0]           i_data_bus,
  input  logic [NUM_NODE-1:0]             i_dest,
  output logic                            o_ready,
  input  logic [NUM_NODE-1:0]             i_node_ready,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_data_bus,
  output logic                            o_en,
  output logic [NUM_NODE-1:0]             o_cmd,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [NUM_NODE-1:0]   mask_mem [FIFO_DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic [NUM_NODE-1:0]   head_mask;
  logic [DATA_WIDTH-1:0] head_data;
  logic [NUM_NODE-1:0]   grant;
  logic                  not_empty;
  logic                  issue;
  logic                  push;
  logic                  pop;

  assign not_empty  = (count_reg != '0);
  assign head_mask  = mask_mem[rd_ptr_reg];
  assign head_data  = data_mem[rd_ptr_reg];
  assign grant      = not_empty ? (head_mask & i_node_ready) : '0;
  assign issue      = not_empty && (grant != '0);

  assign o_ready    = (count_reg < CNT_W'(FIFO_DEPTH));
  assign o_valid    = issue;
  assign o_en       = issue;
  assign o_cmd      = issue ? grant : '0;
  assign o_data_bus = issue ? head_data : '0;
  assign o_count    = count_reg;

  // An empty-mask packet completes its handshake but is never stored.
  assign push = i_valid && o_ready && (i_dest != '0);
  assign pop  = issue && (grant == head_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Write slot and head slot never coincide: equal pointers mean full (no push) or empty (no issue).
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= i_data_bus;
      mask_mem[wr_ptr_reg] <= i_dest;
    end
    if (issue && !pop) begin
      mask_mem[rd_ptr_reg] <= head_mask & ~grant;
    end
  end

endmodule
